// File: rtl/bk_iopage_ctrl_pkg.sv
// Shared types and constants for the BK I/O-page controller.
// Default offsets and vectors reproduce the stock BK register set.
package bk_iopage_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, ACT, HOLD} state_t;

   localparam logic [1:0] LANE_LO = 2'b01;
   localparam logic [1:0] LANE_HI = 2'b10;
   localparam logic [1:0] LANE_W  = 2'b11;

   localparam logic [39:0] DEF_REG_OFS   = {8'o116, 8'o114, 8'o064, 8'o062, 8'o060};
   localparam logic [31:0] DEF_CH_VECTOR = {16'o274, 16'o060};

   // Byte reads return the addressed byte right-justified.
   function automatic logic [15:0] rd_lane(input logic [15:0] w, input logic bt, input logic odd);
      if (!bt)
         return w;
      else if (odd)
         return {8'h00, w[15:8]};
      else
         return {8'h00, w[7:0]};
   endfunction

endpackage

// File: rtl/bk_iopage_ctrl_if.sv
// vm1 bus as seen by the I/O-page controller: CPU cycle controls,
// data, reply/error and the interrupt request/priority pair.
interface bk_iopage_ctrl_if;
   logic        din;
   logic        dout;
   logic        wtbt;
   logic        iako;
   logic [15:0] addr;
   logic [15:0] cpu_data_i;
   logic [15:0] cpu_data_o;
   logic        rply;
   logic        error;
   logic        virq;
   logic [2:0]  cpu_pri;

   modport master (
      output din, dout, wtbt, iako, addr, cpu_data_i, cpu_pri,
      input  cpu_data_o, rply, error, virq
   );

   modport slave (
      input  din, dout, wtbt, iako, addr, cpu_data_i, cpu_pri,
      output cpu_data_o, rply, error, virq
   );
endinterface

// File: rtl/bk_iopage_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder: one-hot of the lowest set request
// plus a valid flag.
module bk_prio_enc #(
   parameter int N = 2
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] onehot,
   output logic         valid
);

   always_comb begin
      onehot = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/bk_iopage_ctrl.sv
// I/O-page controller: table-driven register decode, delayed reply
// and fixed-priority vectored interrupt acknowledge for the vm1 bus.
//   state | meaning
//   IDLE  | waiting for a new bus cycle (sync rising edge)
//   WAIT  | counting reply wait states; sync drop aborts
//   ACT   | one ce cycle with strobes/ack asserted, reply raised
//   HOLD  | reply held until the CPU releases sync
module bk_iopage_ctrl
   import bk_iopage_pkg::*;
#(
   parameter logic [15:0]         BASE        = 16'o177600,
   parameter int                  PAGE_AW     = 7,
   parameter int                  NREG        = 5,
   parameter logic [8*NREG-1:0]   REG_OFS     = DEF_REG_OFS,
   parameter int                  NCH         = 2,
   parameter int                  WAIT_STATES = 0,
   parameter int unsigned         INT_PRI     = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ce,
   bk_iopage_ctrl_if.slave      bus,
   output logic [NREG-1:0]      reg_sel,
   output logic                 reg_wr,
   output logic                 reg_rd,
   output logic [15:0]          reg_wdata,
   output logic [1:0]           reg_wmask,
   input  logic [NREG*16-1:0]   reg_rdata,
   input  logic [NCH-1:0]       ch_req,
   input  logic [NCH*16-1:0]    ch_vector,
   output logic [NCH-1:0]       ch_ack
);

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 syncs_q;
   logic [PAGE_AW-1:0]   ofs_q, ofs_d;
   logic                 wtbt_q, wtbt_d, dout_q, dout_d, iak_q, iak_d;
   logic [15:0]          wd_q, wd_d;
   logic [NCH-1:0]       win_q, win_d;
   logic                 win_v_q, win_v_d;

   logic [NREG-1:0]      sel_q, sel_d;
   logic                 wr_q, wr_d, rd_q, rd_d, rply_q, rply_d, err_q, err_d;
   logic [15:0]          data_q, data_d, wdata_q, wdata_d;
   logic [1:0]           wmask_q, wmask_d;
   logic [NCH-1:0]       ack_q, ack_d;

   logic                 sync, hit, iak_in;
   logic [NCH-1:0]       win_oh;
   logic                 win_v;
   logic [NREG-1:0]      match, idx_oh;
   logic                 idx_v;
   logic [15:0]          rword, vec;

   assign sync   = bus.din | bus.dout;
   assign hit    = bus.addr[15:PAGE_AW] == BASE[15:PAGE_AW];
   assign iak_in = bus.iako & bus.din;

   bk_prio_enc #(.N(NCH)) u_win (.req(ch_req), .onehot(win_oh), .valid(win_v));

   // Odd byte addresses decode to their containing word.
   always_comb begin
      match = '0;
      for (int i = 0; i < NREG; i++)
         match[i] = 8'({ofs_q[PAGE_AW-1:1], 1'b0}) == REG_OFS[8*i +: 8];
   end

   bk_prio_enc #(.N(NREG)) u_idx (.req(match), .onehot(idx_oh), .valid(idx_v));

   always_comb begin
      rword = '0;
      for (int i = 0; i < NREG; i++)
         if (idx_oh[i]) rword = rword | reg_rdata[16*i +: 16];
      vec = '0;
      for (int i = 0; i < NCH; i++)
         if (win_q[i]) vec = vec | ch_vector[16*i +: 16];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ofs_d   = ofs_q;
      wtbt_d  = wtbt_q;
      dout_d  = dout_q;
      iak_d   = iak_q;
      wd_d    = wd_q;
      win_d   = win_q;
      win_v_d = win_v_q;
      sel_d   = sel_q;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      ack_d   = '0;
      rply_d  = rply_q;
      err_d   = err_q;
      data_d  = data_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      case (state_q)
         IDLE: begin
            if (sync && !syncs_q && (hit || iak_in)) begin
               ofs_d   = bus.addr[PAGE_AW-1:0];
               wtbt_d  = bus.wtbt;
               dout_d  = bus.dout;
               iak_d   = iak_in;
               wd_d    = bus.cpu_data_i;
               win_d   = win_oh;
               win_v_d = win_v;
               cnt_d   = WS;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (!sync) begin
               state_d = IDLE;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = ACT;
               if (iak_q) begin
                  if (win_v_q) begin
                     data_d = vec;
                     ack_d  = win_q;
                     rply_d = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (idx_v) begin
                  sel_d  = idx_oh;
                  rply_d = 1'b1;
                  if (dout_q) begin
                     wr_d = 1'b1;
                     if (wtbt_q && ofs_q[0]) begin
                        wmask_d = LANE_HI;
                        wdata_d = {wd_q[7:0], wd_q[7:0]};
                     end else begin
                        wmask_d = wtbt_q ? LANE_LO : LANE_W;
                        wdata_d = wd_q;
                     end
                  end else begin
                     rd_d   = 1'b1;
                     data_d = rd_lane(rword, wtbt_q, ofs_q[0]);
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ACT, HOLD: begin
            if (!sync) begin
               state_d = IDLE;
               rply_d  = 1'b0;
               err_d   = 1'b0;
               sel_d   = '0;
            end else begin
               state_d = HOLD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         syncs_q <= 1'b1;
         ofs_q   <= '0;
         wtbt_q  <= 1'b0;
         dout_q  <= 1'b0;
         iak_q   <= 1'b0;
         wd_q    <= '0;
         win_q   <= '0;
         win_v_q <= 1'b0;
         sel_q   <= '0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         ack_q   <= '0;
         rply_q  <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else if (ce) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         syncs_q <= sync;
         ofs_q   <= ofs_d;
         wtbt_q  <= wtbt_d;
         dout_q  <= dout_d;
         iak_q   <= iak_d;
         wd_q    <= wd_d;
         win_q   <= win_d;
         win_v_q <= win_v_d;
         sel_q   <= sel_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         ack_q   <= ack_d;
         rply_q  <= rply_d;
         err_q   <= err_d;
         data_q  <= data_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
      end
   end

   assign bus.cpu_data_o = data_q;
   assign bus.rply       = rply_q;
   assign bus.error      = err_q;
   assign bus.virq       = (|ch_req) && ({29'd0, bus.cpu_pri} < INT_PRI);
   assign reg_sel        = sel_q;
   assign reg_wr         = wr_q;
   assign reg_rd         = rd_q;
   assign reg_wdata      = wdata_q;
   assign reg_wmask      = wmask_q;
   assign ch_ack         = ack_q;

endmodule

// File: tb/tb_bk_iopage_ctrl.sv
// Bench for bk_iopage_ctrl: two instances (0 and 3 wait states) on a shared
// stimulus, with a scoreboard on the zero-wait instance.
module tb_bk_iopage_ctrl;

   logic        clk = 1'b0;
   logic        reset, ce;
   logic        din, dout, wtbt, iako;
   logic [15:0] addr, cpu_data_i;
   logic [2:0]  cpu_pri;
   logic [79:0] reg_rdata;
   logic [1:0]  ch_req;
   logic [31:0] ch_vector;

   logic [4:0]  sel0, sel3;
   logic        reg_wr0, reg_rd0, reg_wr3, reg_rd3;
   logic [15:0] wdata0, wdata3;
   logic [1:0]  wmask0, wmask3, ch_ack0, ch_ack3;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int det_g = 0;
   int lat3 = -1;
   logic seen3 = 1'b0;

   typedef struct {
      logic        err;
      logic [4:0]  sel;
      logic        rd;
      logic        wr;
      logic [1:0]  ack;
      logic        chkd;
      logic [15:0] data;
      logic [1:0]  wmask;
      logic [15:0] wdata;
      int          det;
   } exp_t;

   exp_t sb[$];

   bk_iopage_ctrl_if b0();
   bk_iopage_ctrl_if b3();

   assign b0.din = din;   assign b3.din = din;
   assign b0.dout = dout; assign b3.dout = dout;
   assign b0.wtbt = wtbt; assign b3.wtbt = wtbt;
   assign b0.iako = iako; assign b3.iako = iako;
   assign b0.addr = addr; assign b3.addr = addr;
   assign b0.cpu_data_i = cpu_data_i; assign b3.cpu_data_i = cpu_data_i;
   assign b0.cpu_pri = cpu_pri;       assign b3.cpu_pri = cpu_pri;

   bk_iopage_ctrl #(.WAIT_STATES(0)) u0 (
      .clk(clk), .reset(reset), .ce(ce), .bus(b0),
      .reg_sel(sel0), .reg_wr(reg_wr0), .reg_rd(reg_rd0),
      .reg_wdata(wdata0), .reg_wmask(wmask0), .reg_rdata(reg_rdata),
      .ch_req(ch_req), .ch_vector(ch_vector), .ch_ack(ch_ack0)
   );

   bk_iopage_ctrl #(.WAIT_STATES(3)) u3 (
      .clk(clk), .reset(reset), .ce(ce), .bus(b3),
      .reg_sel(sel3), .reg_wr(reg_wr3), .reg_rd(reg_rd3),
      .reg_wdata(wdata3), .reg_wmask(wmask3), .reg_rdata(reg_rdata),
      .ch_req(ch_req), .ch_vector(ch_vector), .ch_ack(ch_ack3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0o exp=%0o (octal) at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t mk(input logic err, input logic [4:0] sel, input logic rd,
                               input logic wr, input logic [1:0] ack, input logic chkd,
                               input logic [15:0] data, input logic [1:0] wmask,
                               input logic [15:0] wdata);
      exp_t e;
      e.err = err; e.sel = sel; e.rd = rd; e.wr = wr; e.ack = ack;
      e.chkd = chkd; e.data = data; e.wmask = wmask; e.wdata = wdata; e.det = 0;
      return e;
   endfunction

   // Scoreboard for the zero-wait instance: compare on each reply/error rise.
   initial begin
      logic prev, cur, pend;
      exp_t e;
      prev = 1'b0;
      pend = 1'b0;
      forever begin
         @(negedge clk);
         cur = b0.rply | b0.error;
         if (pend) chk("strobe_pulse", {reg_rd0, reg_wr0, ch_ack0}, 0);
         pend = 1'b0;
         if (cur && !prev) begin
            chk("sb_pending", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("lat0", cyc - e.det, 1);
               chk("error", b0.error, e.err);
               chk("rply", b0.rply, !e.err);
               chk("reg_sel", sel0, e.sel);
               chk("reg_rd", reg_rd0, e.rd);
               chk("reg_wr", reg_wr0, e.wr);
               chk("ch_ack", ch_ack0, e.ack);
               if (e.wr) begin
                  chk("wmask", wmask0, e.wmask);
                  chk("wdata", wdata0, e.wdata);
               end
               if (e.chkd) chk("cpu_data_o", b0.cpu_data_o, e.data);
               pend = 1'b1;
            end
         end
         prev = cur;
      end
   end

   initial begin
      logic prev3, cur3;
      prev3 = 1'b0;
      forever begin
         @(negedge clk);
         cur3 = b3.rply | b3.error;
         if (cur3 && !prev3) lat3 = cyc - det_g;
         if (cur3 || reg_rd3 || reg_wr3) seen3 = 1'b1;
         prev3 = cur3;
      end
   end

   task automatic bus_cycle(input logic [15:0] a, input logic wr, input logic bt,
                            input logic iak, input logic [15:0] wd, input exp_t e,
                            input logic drop_req);
      int n;
      @(negedge clk);
      addr = a; wtbt = bt; cpu_data_i = wd; iako = iak; din = !wr; dout = wr;
      lat3 = -1;
      e.det = cyc + 1;
      det_g = cyc + 1;
      sb.push_back(e);
      n = 0;
      if (drop_req) begin
         @(negedge clk);
         ch_req = 2'b00;
         n = 1;
      end
      while (!((b0.rply | b0.error) && (b3.rply | b3.error)) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("reply_timeout", n >= 40, 0);
      @(negedge clk);
      din = 0; dout = 0; iako = 0; wtbt = 0;
      @(negedge clk);
      chk("release0", {b0.rply, b0.error, sel0}, 0);
      chk("release3", {b3.rply, b3.error, sel3}, 0);
      chk("lat3", lat3, 4);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int n;
      logic any0;
      reset = 1; ce = 1; din = 0; dout = 0; wtbt = 0; iako = 0;
      addr = 0; cpu_data_i = 0; cpu_pri = 0; ch_req = 0;
      ch_vector = {16'o274, 16'o060};
      reg_rdata = {16'o170017, 16'o044444, 16'o001330, 16'o000222, 16'o000011};
      repeat (3) @(negedge clk);
      chk("rst_out", {b0.rply, b0.error, sel0, reg_rd0, reg_wr0, ch_ack0}, 0);
      chk("rst_data", b0.cpu_data_o, 0);
      chk("rst_virq", b0.virq, 0);
      reset = 0;
      @(negedge clk);

      bus_cycle(16'o177664, 0, 0, 0, 0, mk(0, 5'b00100, 1, 0, 0, 1, 16'o001330, 0, 0), 0);
      bus_cycle(16'o177661, 1, 1, 0, 16'o000100, mk(0, 5'b00001, 0, 1, 0, 0, 0, 2'b10, 16'o040100), 0);
      bus_cycle(16'o177662, 1, 1, 0, 16'o123456, mk(0, 5'b00010, 0, 1, 0, 0, 0, 2'b01, 16'o123456), 0);
      bus_cycle(16'o177714, 1, 0, 0, 16'o055555, mk(0, 5'b01000, 0, 1, 0, 0, 0, 2'b11, 16'o055555), 0);
      bus_cycle(16'o177717, 0, 1, 0, 0, mk(0, 5'b10000, 1, 0, 0, 1, 16'o000360, 0, 0), 0);
      bus_cycle(16'o177716, 0, 1, 0, 0, mk(0, 5'b10000, 1, 0, 0, 1, 16'o000017, 0, 0), 0);
      bus_cycle(16'o177600, 0, 0, 0, 0, mk(1, 5'b00000, 0, 0, 0, 0, 0, 0, 0), 0);

      ch_req = 2'b11; cpu_pri = 0; #1;
      chk("virq_pri0", b0.virq, 1);
      cpu_pri = 1; #1;
      chk("virq_pri1", b0.virq, 0);
      cpu_pri = 0;
      bus_cycle(16'o000000, 0, 0, 1, 0, mk(0, 0, 0, 0, 2'b01, 1, 16'o060, 0, 0), 0);
      ch_req = 2'b10;
      bus_cycle(16'o000000, 0, 0, 1, 0, mk(0, 0, 0, 0, 2'b10, 1, 16'o274, 0, 0), 0);
      ch_req = 2'b00; #1;
      chk("virq_none", b0.virq, 0);
      bus_cycle(16'o000000, 0, 0, 1, 0, mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0), 0);
      ch_req = 2'b01;
      bus_cycle(16'o000000, 0, 0, 1, 0, mk(0, 0, 0, 0, 2'b01, 1, 16'o060, 0, 0), 1);

      // Out-of-page cycle without IAK must be ignored.
      @(negedge clk);
      addr = 16'o001000; din = 1; any0 = 0; seen3 = 0;
      repeat (5) begin
         @(negedge clk);
         any0 = any0 | b0.rply | b0.error | reg_rd0;
      end
      chk("nonhit_ignored0", any0, 0);
      chk("nonhit_ignored3", seen3, 0);
      din = 0;
      @(negedge clk);

      // Early release on the 3-wait instance while it is still counting.
      @(negedge clk);
      seen3 = 0;
      addr = 16'o177664; din = 1;
      det_g = cyc + 1;
      begin
         exp_t e;
         e = mk(0, 5'b00100, 1, 0, 0, 1, 16'o001330, 0, 0);
         e.det = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clk);
      @(negedge clk);
      din = 0;
      repeat (6) @(negedge clk);
      chk("abort_quiet3", seen3, 0);
      chk("abort_idle0", {b0.rply, b0.error, sel0}, 0);
      bus_cycle(16'o177660, 0, 0, 0, 0, mk(0, 5'b00001, 1, 0, 0, 1, 16'o000011, 0, 0), 0);

      // Reset during HOLD with din still asserted, and with ce low.
      @(negedge clk);
      addr = 16'o177664; din = 1;
      begin
         exp_t e;
         e = mk(0, 5'b00100, 1, 0, 0, 1, 16'o001330, 0, 0);
         e.det = cyc + 1;
         sb.push_back(e);
      end
      n = 0;
      while (!b0.rply && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("hold_reply_timeout", n >= 20, 0);
      @(negedge clk);
      reset = 1; ce = 0;
      @(negedge clk);
      chk("midrst_out", {b0.rply, b0.error, sel0}, 0);
      chk("midrst_data", b0.cpu_data_o, 0);
      reset = 0; ce = 1;
      any0 = 0; seen3 = 0;
      repeat (4) begin
         @(negedge clk);
         any0 = any0 | b0.rply | b0.error | reg_rd0;
      end
      chk("no_redetect0", any0, 0);
      chk("no_redetect3", seen3, 0);
      din = 0;
      @(negedge clk);
      bus_cycle(16'o177664, 0, 0, 0, 0, mk(0, 5'b00100, 1, 0, 0, 1, 16'o001330, 0, 0), 0);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bk_iopage_ctrl.md
Name: bk_iopage_ctrl

Overview:
- Parametrised I/O-page controller for the BK core's vm1 bus (DIN/DOUT/WTBT/IAKO/RPLY).
- Replaces the hard-wired register decode, reply generation and single keyboard interrupt with three generalised functions:
  - a table-driven register map of NREG peripheral registers;
  - configurable reply wait states;
  - an NCH-channel fixed-priority vectored interrupt arbiter.
- Sits between the CPU and the peripheral register blocks (keyboard, scroll, init/tape, user port). RAM/ROM reply paths are untouched.

Parameters:
- BASE, 16'o177600: I/O page base byte address, aligned to 2**PAGE_AW.
- PAGE_AW, 7: page span is 2**PAGE_AW bytes.
- NREG, 5: number of mapped registers.
- REG_OFS, {8'o116,8'o114,8'o064,8'o062,8'o060}: packed NREG×8 even byte offsets within the page; entry i sits at bits [8i+7:8i].
- NCH, 2: interrupt channels; channel 0 has the highest priority.
- WAIT_STATES, 0: extra ce cycles between cycle detection and RPLY, range 0..15.
- INT_PRI, 1: VIRQ is allowed only while cpu_pri < INT_PRI.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- ce  in  1  clock enable; all state advances only when ce=1
- din  in  1  CPU data-in cycle
- dout  in  1  CPU data-out cycle
- wtbt  in  1  byte access
- iako  in  1  interrupt acknowledge (qualified by din)
- addr  in  16  CPU address
- cpu_data_i  in  16  write data from CPU
- cpu_data_o  out  16  read data / vector to CPU, registered
- rply  out  1  reply for I/O-page and IAK cycles
- error  out  1  bus error
- virq  out  1  vectored interrupt request
- cpu_pri  in  3  PSW[7:5]
- reg_sel  out  NREG  one-hot register select, registered
- reg_wr  out  1  one-ce write strobe
- reg_rd  out  1  one-ce read strobe (side-effect reads)
- reg_wdata  out  16  write data
- reg_wmask  out  2  byte lanes {hi,lo}
- reg_rdata  in  NREG×16  per-register read data
- ch_req  in  NCH  level interrupt requests
- ch_vector  in  NCH×16  per-channel vector
- ch_ack  out  NCH  one-ce acknowledge pulse

Behaviour:
- Reset, synchronous and active-high, clears everything:
  - all outputs 0;
  - state=IDLE, wait counter=0;
  - syncsample=1, so a cycle already in progress at reset release is not re-detected; a new cycle needs sync to fall first.
- Definitions:
  - sync = din|dout.
  - hit = addr[15:PAGE_AW]==BASE[15:PAGE_AW].
  - idx = lowest i with addr[PAGE_AW-1:0]==REG_OFS[i] (odd addr compares with bit0 cleared).
  - mapped = hit and idx exists.
- IDLE:
  - Start condition on a ce cycle: sync & ~syncsample & (hit | (iako&din)).
  - On start, latch addr, wtbt, dout, iako, cpu_data_i and winner, then go to WAIT.
  - A non-hit cycle without iako is ignored.
- WAIT:
  - Count WAIT_STATES ce cycles, then act on the following ce cycle.
  - With WAIT_STATES=0, the action occurs on the ce cycle right after detection.
- Action (exactly one ce cycle), then go to HOLD:
  - mapped write:
    - reg_sel=onehot(idx), reg_wr=1.
    - wtbt&addr[0]: wmask=10, wdata={d[7:0],d[7:0]}.
    - wtbt&~addr[0]: wmask=01, wdata=d.
    - word: wmask=11, wdata=d.
  - mapped read:
    - reg_sel, reg_rd=1.
    - cpu_data_o = word, or {8'o0,rdata[15:8]} for byte odd, or {8'o0,rdata[7:0]} for byte even.
  - unmapped hit: error=1, no strobe.
    - A write to a mapped register with byte/word mismatch is still legal.
  - IAK with a winner: cpu_data_o=ch_vector[winner], ch_ack[winner]=1.
  - IAK with no request pending: error=1, no ack.
  - rply=1 in every case except error.
- HOLD:
  - rply/error and cpu_data_o are held; reg_sel stays, strobes are 0.
  - When sync=0: drop rply/error, clear reg_sel, return to IDLE on that same ce cycle.
- Early release: if sync drops during WAIT, abort to IDLE with no strobe and no reply.
- Interrupt arbitration:
  - virq = |ch_req & (cpu_pri<INT_PRI), combinational from inputs.
  - winner = lowest-index asserted ch_req, sampled at IAK detection.
  - A request dropping between detection and action still receives the latched vector.
- Reset asserted mid-cycle: immediate return to the reset state; outputs clear on that edge, regardless of ce.

Decomposition:
- Package bk_iopage_pkg holds:
  - state enum {IDLE, WAIT, ACT, HOLD};
  - lane-mask constants LANE_LO=2'b01, LANE_HI=2'b10, LANE_W=2'b11;
  - the default BK register offsets and vectors (8'o060, 8'o274).
- Sub-module bk_prio_enc(N): lowest-index priority encoder producing one-hot output plus a valid bit. Used for the interrupt winner and reused for reg idx matching.

Test Plan:
- Word read 177664, WAIT_STATES=0, rdata[2]=16'o001330 → reg_rd pulse, reg_sel=5'b00100, cpu_data_o=16'o001330, rply 1 ce after detection, held until din drops.
- Byte write odd 177661, data 16'o000100 → reg_wr, reg_sel=5'b00001, wmask=10, wdata=16'o040100. Repeat with WAIT_STATES=3 → rply 4 ce after detection.
- Read 177600 (unmapped) → error=1, rply=0, no strobes; error clears when din drops.
- ch_req=2'b11, cpu_pri=0, ch_vector={16'o274,16'o060} → virq=1; IAK cycle returns 16'o060, ch_ack=01. cpu_pri=1 → virq=0.
- Reset asserted in HOLD with din still high → outputs 0 next edge; no new cycle until din falls and rises again.
- din rising then falling during WAIT (WAIT_STATES=5) → no strobe, no rply, back to IDLE.
